// File: rtl/ps2_key_matrix.sv
// PS/2 keyboard responder: receives scancodes, keeps a 12x6 pressed-key matrix
// and answers the CPU column scan combinationally on active-low row lines.
module ps2_key_matrix #(
    parameter logic [15:0] TIMEOUT = 16'd50000,
    parameter int unsigned FILTER  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic [11:0] col_n,
    output logic [5:0]  row_n,
    output logic        shift_n,
    output logic        key_reset,
    output logic        frame_err
);

    localparam int unsigned FW = (FILTER > 1) ? $clog2(FILTER) : 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    logic          clk_meta, clk_s, dat_meta, dat_s;
    logic          clk_f;
    logic [FW-1:0] fcnt;
    logic          edge_c, fall_c;
    logic [15:0]   tmo;
    rx_state_t     state;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          par_ok;
    logic          byte_valid;
    logic          ext, brk, lshift, rshift;
    logic [5:0][11:0] key;

    // Two-flop synchronizers; lines idle high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_meta <= 1'b1;
            clk_s    <= 1'b1;
            dat_meta <= 1'b1;
            dat_s    <= 1'b1;
        end else begin
            clk_meta <= ps2_clk;
            clk_s    <= clk_meta;
            dat_meta <= ps2_data;
            dat_s    <= dat_meta;
        end
    end

    // Glitch filter: clk_f follows clk_s only after FILTER consecutive differing samples
    assign edge_c = (clk_s != clk_f) && (fcnt == FW'(FILTER - 1));
    assign fall_c = edge_c && !clk_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_f <= 1'b1;
            fcnt  <= '0;
        end else if (clk_s != clk_f) begin
            if (edge_c) begin
                clk_f <= clk_s;
                fcnt  <= '0;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end else begin
            fcnt <= '0;
        end
    end

    // Inactivity counter, saturating at TIMEOUT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo <= '0;
        end else if (edge_c) begin
            tmo <= '0;
        end else if (tmo != TIMEOUT) begin
            tmo <= tmo + 16'd1;
        end
    end

    // Frame receiver; a falling edge takes priority over the timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bitcnt     <= '0;
            shreg      <= '0;
            par_ok     <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall_c) begin
                case (state)
                    IDLE: begin
                        if (!dat_s) begin
                            state  <= DATA;
                            bitcnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg  <= {dat_s, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_ok <= ^{shreg, dat_s};
                        state  <= STOP;
                    end
                    default: begin
                        if (dat_s && par_ok) byte_valid <= 1'b1;
                        else                 frame_err  <= 1'b1;
                        state <= IDLE;
                    end
                endcase
            end else if (state != IDLE && tmo == TIMEOUT) begin
                state <= IDLE;
            end
        end
    end

    // Keymap lookup: {hit, row[2:0], col[3:0]}
    function automatic logic [7:0] keymap(input logic e, input logic [7:0] code);
        logic [7:0] m;
        m = 8'h00;
        case ({e, code})
            9'h01C:  m = {1'b1, 3'd2, 4'd4};
            9'h05A:  m = {1'b1, 3'd0, 4'd0};
            9'h029:  m = {1'b1, 3'd0, 4'd6};
            9'h16B:  m = {1'b1, 3'd0, 4'd9};
            default: m = 8'h00;
        endcase
        return m;
    endfunction

    logic [7:0] map_c;
    assign map_c = keymap(ext, shreg);

    // Scancode decoder, acting on the byte-valid cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext       <= 1'b0;
            brk       <= 1'b0;
            lshift    <= 1'b0;
            rshift    <= 1'b0;
            key_reset <= 1'b0;
            key       <= '0;
        end else begin
            key_reset <= 1'b0;
            if (byte_valid) begin
                if (shreg == 8'hE0) begin
                    ext <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (!ext && shreg == 8'h12)      lshift <= ~brk;
                    else if (!ext && shreg == 8'h59) rshift <= ~brk;
                    else if (!ext && shreg == 8'h07) key_reset <= ~brk;
                    else if (map_c[7])               key[map_c[6:4]][map_c[3:0]] <= ~brk;
                end
            end
        end
    end

    assign shift_n = ~(lshift | rshift);

    // Asynchronous scan answer: a row is pulled low if any selected column has a pressed key
    always_comb begin
        row_n = 6'h3F;
        for (int r = 0; r < 6; r++) begin
            row_n[r] = ~|(key[r] & ~col_n);
        end
    end

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Scoreboard bench for ps2_key_matrix: stimulus queues expected responses,
// a negedge monitor pops and compares whenever the DUT presents an output.
module tb_ps2_key_matrix;

    logic        clk = 1'b0;
    logic        reset;
    logic        ps2_clk;
    logic        ps2_data;
    logic [11:0] col_n;
    logic [5:0]  row_n;
    logic        shift_n;
    logic        key_reset;
    logic        frame_err;
    logic        scan_req = 1'b0;

    typedef struct {
        int         kind;   // 0 scan, 1 frame_err pulse, 2 key_reset pulse
        logic [5:0] row;
        logic       shift;
        string      name;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    ps2_key_matrix #(.TIMEOUT(16'd400), .FILTER(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .col_n     (col_n),
        .row_n     (row_n),
        .shift_n   (shift_n),
        .key_reset (key_reset),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic pop_expect(input int kind, input string what, output exp_t e, output bit ok);
        checks++;
        ok = 1'b0;
        e.kind = -1; e.row = '0; e.shift = 1'b0; e.name = "";
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s: output seen but nothing expected", what);
        end else begin
            e = q.pop_front();
            if (e.kind != kind) begin
                errors++;
                $display("FAIL %s: got output kind %0d, required kind %0d (%s)", what, kind, e.kind, e.name);
            end else begin
                ok = 1'b1;
            end
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        if (!reset) begin
            if (frame_err) pop_expect(1, "frame_err", e, ok);
            if (key_reset) pop_expect(2, "key_reset", e, ok);
            if (scan_req) begin
                pop_expect(0, "scan", e, ok);
                if (ok && (row_n !== e.row || shift_n !== e.shift || key_reset !== 1'b0 || frame_err !== 1'b0)) begin
                    errors++;
                    $display("FAIL %s: row_n=%b shift_n=%b pulses=%b%b, required row_n=%b shift_n=%b pulses=00",
                             e.name, row_n, shift_n, key_reset, frame_err, e.row, e.shift);
                end
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_event(input int kind, input string name);
        exp_t e;
        e.kind = kind; e.row = '0; e.shift = 1'b0; e.name = name;
        q.push_back(e);
    endtask

    task automatic scan(input logic [11:0] col, input logic [5:0] row, input logic shift, input string name);
        exp_t e;
        e.kind = 0; e.row = row; e.shift = shift; e.name = name;
        wait_clks(1);
        col_n = col;
        q.push_back(e);
        scan_req = 1'b1;
        wait_clks(1);
        scan_req = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_clks(10);
        ps2_clk = 1'b0;
        wait_clks(20);
        ps2_clk = 1'b1;
        wait_clks(10);
    endtask

    function automatic logic [10:0] build(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic frame(input logic [7:0] b, input logic bad_par = 1'b0, input logic bad_stop = 1'b0);
        logic [10:0] f;
        f = build(b, bad_par, bad_stop);
        for (int i = 0; i < 11; i++) send_bit(f[i]);
        ps2_data = 1'b1;
        wait_clks(30);
    endtask

    task automatic partial(input logic [7:0] b, input int nbits);
        logic [10:0] f;
        f = build(b, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(f[i]);
        ps2_data = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        col_n    = 12'hFFF;
        wait_clks(5);
        reset = 1'b0;
        wait_clks(5);

        scan(12'h000, 6'h3F, 1'b1, "reset_state");

        frame(8'h1C);
        scan(~12'(1 << 4), 6'b111011, 1'b1, "a_col4");
        scan(~12'(1 << 5), 6'h3F,     1'b1, "a_col5");
        scan(12'h000,      6'b111011, 1'b1, "a_all_cols");

        frame(8'hF0); frame(8'h1C);
        scan(~12'(1 << 4), 6'h3F, 1'b1, "a_break");

        frame(8'hE0); frame(8'h6B);
        scan(~12'(1 << 9), 6'b111110, 1'b1, "ext_left");
        frame(8'h6B);
        scan(12'h000, 6'b111110, 1'b1, "kp4_unmapped");

        expect_event(1, "bad_parity_err");
        frame(8'h5A, 1'b1);
        scan(~12'(1 << 0), 6'h3F, 1'b1, "bad_parity_dropped");
        frame(8'h5A);
        scan(~12'(1 << 0), 6'b111110, 1'b1, "enter");
        scan(~12'((1 << 0) | (1 << 9)), 6'b111110, 1'b1, "enter_left_or");

        frame(8'h1C); frame(8'h1C);
        scan(~12'((1 << 0) | (1 << 4)), 6'b111010, 1'b1, "enter_a_rows");
        frame(8'hF0); frame(8'h1C);
        scan(~12'(1 << 4), 6'h3F, 1'b1, "a_repeat_release");

        partial(8'h29, 5);
        wait_clks(500);
        frame(8'h12);
        scan(12'hFFF,      6'h3F, 1'b0, "lshift_after_timeout");
        scan(~12'(1 << 6), 6'h3F, 1'b0, "space_dropped");

        expect_event(2, "f12_make");
        frame(8'h07);
        scan(12'hFFF, 6'h3F, 1'b0, "after_f12");
        expect_event(2, "f12_repeat");
        frame(8'h07);
        frame(8'hF0); frame(8'h07);
        scan(12'hFFF, 6'h3F, 1'b0, "f12_break_quiet");

        frame(8'h59);
        frame(8'hF0); frame(8'h12);
        scan(12'hFFF, 6'h3F, 1'b0, "rshift_held");
        frame(8'hF0); frame(8'h59);
        scan(12'hFFF, 6'h3F, 1'b1, "shift_released");

        expect_event(1, "start_bit_err");
        send_bit(1'b1);
        wait_clks(30);
        expect_event(1, "stop_bit_err");
        frame(8'h29, 1'b0, 1'b1);
        scan(~12'(1 << 6), 6'h3F, 1'b1, "bad_stop_dropped");

        frame(8'h1C);
        partial(8'h5A, 4);
        reset = 1'b1;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(5);
        scan(12'h000, 6'h3F, 1'b1, "reset_mid_frame");
        frame(8'h5A);
        scan(~12'(1 << 0), 6'b111110, 1'b1, "enter_after_reset");

        wait_clks(20);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending: %0d expected outputs never seen, required 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
